line_mem_port: RTL and testbench

//   Main-memory side of the cache refill/writeback path. Accepts one line request
//   (1024-bit line = 32 words of 4 byte lanes), waits LATENCY cycles, then streams
//   32 word beats to the cache (read) or absorbs 32 word beats from it (write).

---
 rtl/line_mem_port_if.sv | 24 ++
 rtl/line_mem_port.sv | 111 +++++++++++
 tb/tb_line_mem_port.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/line_mem_port_if.sv
// Cache-to-main-memory line port: request handshake, write beat lanes and read beat lanes.
// The master (cache) issues requests and write beats; the slave (memory) returns read beats.
interface line_mem_port_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic        req_ready;
    logic [7:0]  wr_byte [0:3];
    logic        wr_en;
    logic [7:0]  rd_byte [0:3];
    logic        rd_valid;
    logic [4:0]  beat_idx;
    logic        done;

    modport master (
        output req_valid, req_write, req_addr, wr_byte, wr_en,
        input  req_ready, rd_byte, rd_valid, beat_idx, done
    );

    modport slave (
        input  req_valid, req_write, req_addr, wr_byte, wr_en,
        output req_ready, rd_byte, rd_valid, beat_idx, done
    );
endinterface

// File: rtl/line_mem_port.sv
// Main-memory side of the cache refill/writeback path: accepts one 32-word line request,
// waits LATENCY cycles, then streams 32 read beats out or absorbs 32 write beats in.
module line_mem_port #(
    parameter int ADDR_W  = 13,
    parameter int LATENCY = 4
) (
    input logic            clk,
    input logic            rst,
    line_mem_port_if.slave bus
);
    localparam int LINE_W = ADDR_W - 5;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

    state_t            state;
    logic [LINE_W-1:0] cur_line;
    logic              is_write;
    logic [3:0]        wait_cnt;
    logic [4:0]        next_beat;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       wr_word;
    logic              mem_we;
    logic [31:0]       mem [DEPTH];

    // Byte-address bits outside the line field are don't-care; addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[6:0]};

    // The read port looks one beat ahead so rd_byte is registered alongside beat_idx.
    always_comb begin
        next_beat = bus.beat_idx + 5'd1;
        rd_addr   = (state == XFER) ? {cur_line, next_beat} : {cur_line, 5'd0};
        wr_word   = {bus.wr_byte[3], bus.wr_byte[2], bus.wr_byte[1], bus.wr_byte[0]};
        mem_we    = !rst && (state == XFER) && is_write && bus.wr_en;
    end

    // Memory contents are never cleared; a reset only stops further beats landing.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[{cur_line, bus.beat_idx}] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            bus.req_ready <= 1'b1;
            bus.rd_valid  <= 1'b0;
            bus.beat_idx  <= '0;
            bus.done      <= 1'b0;
            for (int i = 0; i < 4; i++)
                bus.rd_byte[i] <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        state         <= WAIT;
                        bus.req_ready <= 1'b0;
                        cur_line      <= bus.req_addr[ADDR_W+1:7];
                        is_write      <= bus.req_write;
                        wait_cnt      <= '0;
                    end
                end
                WAIT: begin
                    if (wait_cnt == LAT_LAST) begin
                        state        <= XFER;
                        bus.beat_idx <= '0;
                        if (!is_write) begin
                            bus.rd_valid <= 1'b1;
                            for (int i = 0; i < 4; i++)
                                bus.rd_byte[i] <= mem[rd_addr][8*i +: 8];
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                XFER: begin
                    if (is_write) begin
                        // Writes advance only on beats the cache actually presents.
                        if (bus.wr_en) begin
                            if (bus.beat_idx == 5'd31) begin
                                state        <= DONE;
                                bus.done     <= 1'b1;
                                bus.beat_idx <= '0;
                            end else begin
                                bus.beat_idx <= next_beat;
                            end
                        end
                    end else if (bus.beat_idx == 5'd31) begin
                        state        <= DONE;
                        bus.done     <= 1'b1;
                        bus.rd_valid <= 1'b0;
                        bus.beat_idx <= '0;
                    end else begin
                        bus.beat_idx <= next_beat;
                        for (int i = 0; i < 4; i++)
                            bus.rd_byte[i] <= mem[rd_addr][8*i +: 8];
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_mem_port.sv
// Bench for line_mem_port: a stimulus process issues line transfers and queues the expected
// read beats and done pulses (with their cycle numbers); a monitor pops and compares them.
module tb_line_mem_port;
    localparam int ADDR_W = 13;
    localparam int LAT    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    line_mem_port_if bus ();

    line_mem_port #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } beat_t;

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    beat_t       rd_q[$];
    int          done_q[$];
    logic [31:0] mem_model [int];
    logic [31:0] wdata [32];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_word();
        return {bus.rd_byte[3], bus.rd_byte[2], bus.rd_byte[1], bus.rd_byte[0]};
    endfunction

    function automatic int line_of(input logic [31:0] addr);
        return int'((addr >> 7) % 32'(1 << (ADDR_W - 5)));
    endfunction

    // Monitor: every presented beat or done pulse must match the head of its queue.
    always @(negedge clk) begin
        beat_t b;
        int    dc;
        if (bus.rd_valid === 1'b1) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                b = rd_q.pop_front();
                check("rd_cycle", cyc, b.cyc);
                check("rd_data", rd_word(), b.data);
            end
        end
        if (bus.done === 1'b1) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                dc = done_q.pop_front();
                check("done_cycle", cyc, dc);
            end
        end
    end

    task automatic drive_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            bus.wr_byte[i] = w[8*i +: 8];
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, output int n);
        check("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        @(negedge clk);
        n = cyc;
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = $urandom;
    endtask

    task automatic push_read(input logic [31:0] addr, input int n);
        beat_t e;
        int    ln;
        ln = line_of(addr);
        for (int b = 0; b < 32; b++) begin
            e.cyc  = n + LAT + b;
            e.data = mem_model[ln * 32 + b];
            rd_q.push_back(e);
        end
        done_q.push_back(n + LAT + 32);
    endtask

    task automatic read_line(input logic [31:0] addr);
        int n;
        int ln;
        ln = line_of(addr);
        issue(1'b0, addr, n);
        push_read(addr, n);
        repeat (LAT + 33) @(negedge clk);
        check("req_ready_after_rd", bus.req_ready, 1'b1);
        check("rd_hold", rd_word(), mem_model[ln * 32 + 31]);
    endtask

    // mode 0: wr_en every cycle, 1: alternate 1/0, 2: random. rst_at >= 0 resets before that beat.
    task automatic write_line(input logic [31:0] addr, input int mode, input int rst_at);
        int   n;
        int   k;
        int   ph;
        int   ln;
        logic en;
        ln = line_of(addr);
        issue(1'b1, addr, n);
        repeat (LAT) begin
            bus.wr_en = 1'b1;
            drive_word($urandom);
            @(negedge clk);
        end
        k  = 0;
        ph = 0;
        while (k < 32) begin
            check("beat_idx", 32'(bus.beat_idx), k);
            check("rd_valid_wr", bus.rd_valid, 1'b0);
            if (k == rst_at) begin
                rst       = 1'b1;
                bus.wr_en = 1'b1;
                drive_word(wdata[k]);
                @(negedge clk);
                rst       = 1'b0;
                bus.wr_en = 1'b0;
                check("rst_req_ready", bus.req_ready, 1'b1);
                check("rst_rd_valid", bus.rd_valid, 1'b0);
                check("rst_beat_idx", 32'(bus.beat_idx), 32'd0);
                check("rst_done", bus.done, 1'b0);
                check("rst_rd_byte", rd_word(), 32'd0);
                return;
            end
            if (mode == 0)      en = 1'b1;
            else if (mode == 1) en = ((ph % 2) == 0);
            else                en = 1'($urandom_range(0, 1));
            if (en) begin
                bus.wr_en = 1'b1;
                drive_word(wdata[k]);
                mem_model[ln * 32 + k] = wdata[k];
                k++;
                if (k == 32) done_q.push_back(cyc + 1);
            end else begin
                bus.wr_en = 1'b0;
                drive_word($urandom);
            end
            ph++;
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        check("req_ready_done", bus.req_ready, 1'b0);
        @(negedge clk);
        check("req_ready_after_wr", bus.req_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          ln;
        logic [31:0] addr;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.wr_en     = 1'b0;
        drive_word('0);
        repeat (2) @(negedge clk);
        check("reset_req_ready", bus.req_ready, 1'b1);
        check("reset_rd_valid", bus.rd_valid, 1'b0);
        check("reset_beat_idx", 32'(bus.beat_idx), 32'd0);
        check("reset_done", bus.done, 1'b0);
        check("reset_rd_byte", rd_word(), 32'd0);
        rst = 1'b0;

        // Line 0 with lanes {b, b+1, b+2, b+3}, then read it back.
        for (int b = 0; b < 32; b++)
            wdata[b] = {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
        write_line(32'h0000_0000, 0, -1);
        read_line(32'h0000_0000);

        // Line 1 with stalls every other cycle, then both lines read back.
        for (int b = 0; b < 32; b++) wdata[b] = $urandom;
        write_line(32'h0000_0080, 1, -1);
        read_line(32'h0000_0080);
        read_line(32'h0000_0000);

        // Aliased address lands on line 0.
        read_line(32'h4000_0000);

        // req_valid held high: second request waits until the cycle after DONE.
        check("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_0000;
        @(negedge clk);
        n = cyc;
        push_read(32'h0000_0000, n);
        bus.req_addr = 32'h0000_0080;
        for (int i = 0; i < LAT + 33; i++) begin
            check("req_ready_busy", bus.req_ready, 1'b0);
            @(negedge clk);
        end
        check("req_ready_reopen", bus.req_ready, 1'b1);
        @(negedge clk);
        n = cyc;
        bus.req_valid = 1'b0;
        push_read(32'h0000_0080, n);
        repeat (LAT + 33) @(negedge clk);

        // Line 2: random fill, then an 8'hAA write cut off by reset at beat 10.
        for (int b = 0; b < 32; b++) wdata[b] = $urandom;
        write_line(32'h0000_0100, 2, -1);
        for (int b = 0; b < 32; b++) wdata[b] = 32'hAAAA_AAAA;
        write_line(32'h0000_0100, 0, 10);
        @(negedge clk);
        read_line(32'h0000_0100);

        // Random lines with aliased address bits and random stall patterns.
        for (int t = 0; t < 6; t++) begin
            ln   = int'($urandom_range(0, (1 << (ADDR_W - 5)) - 1));
            addr = ($urandom & 32'hFFFF_8000) | (32'(ln) << 7) | ($urandom & 32'h7F);
            for (int b = 0; b < 32; b++) wdata[b] = $urandom;
            write_line(addr, int'($urandom_range(0, 2)), -1);
            addr = ($urandom & 32'hFFFF_8000) | (32'(ln) << 7) | ($urandom & 32'h7F);
            read_line(addr);
        end
        read_line(32'h0000_0000);

        repeat (3) @(negedge clk);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        check("done_queue_drained", 32'(done_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
